// File: rtl/mfp_clock_speed_controller_pkg.sv
// Speed code enum and request arbitration helper for the clock speed controller.
`include "mfp_clock_speed.vh"

package mfp_clock_speed_controller_pkg;

    typedef enum logic [1:0] {
        SPEED_FAST = `MFP_SPEED_FAST,
        SPEED_MID  = `MFP_SPEED_MID,
        SPEED_LO   = `MFP_SPEED_LO,
        SPEED_HALT = `MFP_SPEED_HALT
    } speed_e;

    // Loader beats software override, which beats the board switches.
    function automatic speed_e pick_target(
        input logic   ldr_active,
        input logic   override,
        input speed_e sys_latch,
        input logic   sel_lo,
        input logic   sel_mid
    );
        if (ldr_active)   return SPEED_FAST;
        else if (override) return sys_latch;
        else if (sel_lo)  return SPEED_LO;
        else if (sel_mid) return SPEED_MID;
        else              return SPEED_FAST;
    endfunction

endpackage

// File: rtl/mfp_clock_speed.vh
// Speed codes shared by the clock speed controller and the software register decode.
`ifndef MFP_CLOCK_SPEED_VH
`define MFP_CLOCK_SPEED_VH

`define MFP_SPEED_FAST 2'd0
`define MFP_SPEED_MID  2'd1
`define MFP_SPEED_LO   2'd2
`define MFP_SPEED_HALT 2'd3

`endif

// File: rtl/mfp_clock_tick_gen.sv
// Free-running period counter with end-of-period detect, registered clk_en and clko.
module mfp_clock_tick_gen #(
    parameter int CNT_W = 26,
    parameter int POW_W = 5
) (
    input  logic             clki,
    input  logic             rst,
    input  logic [POW_W-1:0] pow,
    input  logic             run,
    input  logic             clear,
    input  logic             step_fire,
    output logic             eop,
    output logic             clk_en,
    output logic             clko
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] mask;
    logic [CNT_W-1:0] msb_mask;
    logic             clko_bit;

    // mask covers cnt[pow-1:0]; msb_mask isolates cnt[pow-1] for the square wave.
    always_comb begin
        mask     = ~({CNT_W{1'b1}} << pow);
        msb_mask = mask ^ (mask >> 1);
        eop      = ((cnt & mask) == mask);
        clko_bit = |(cnt & msb_mask);
    end

    always_ff @(posedge clki) begin
        if (rst) begin
            cnt    <= '0;
            clk_en <= 1'b0;
            clko   <= 1'b0;
        end else begin
            clk_en <= run ? eop : step_fire;
            clko   <= run ? clko_bit : step_fire;
            if (clear) begin
                cnt <= '0;
            end else if (run) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mfp_clock_speed_controller.sv
// Arbitrates CPU clock speed requests and applies changes only at period boundaries.
// Define MFP_CLOCK_SINGLE_STEP_EN to add the step port for single-stepping while halted.
module mfp_clock_speed_controller
    import mfp_clock_speed_controller_pkg::*;
#(
    parameter int DIV_POW_FASTEST = 1,
    parameter int DIV_POW_MID     = 22,
    parameter int DIV_POW_SLOWEST = 26
) (
    input  logic       clki,
    input  logic       rst,
    input  logic       sw_sel_lo,
    input  logic       sw_sel_mid,
    input  logic       ldr_active,
    input  logic       sys_req,
    input  logic [1:0] sys_speed,
    input  logic       sys_rel,
    output logic       sys_ack,
`ifdef MFP_CLOCK_SINGLE_STEP_EN
    input  logic       step,
`endif
    output logic       clk_en,
    output logic       clko,
    output logic [1:0] cur_speed,
    output logic       pending
);

    localparam int POW_W = $clog2(DIV_POW_SLOWEST + 1);

    speed_e           cur;
    speed_e           sys_latch;
    speed_e           target;
    speed_e           req_speed;
    logic             override;
    logic             ack_wait;
    logic             eop;
    logic             boundary;
    logic             do_switch;
    logic             run;
    logic             step_fire;
    logic [POW_W-1:0] pow;

    assign cur_speed = cur;
    assign req_speed = speed_e'(sys_speed);

    always_comb begin
        target = pick_target(ldr_active, override, sys_latch, sw_sel_lo, sw_sel_mid);
        case (cur)
            SPEED_MID: pow = POW_W'(DIV_POW_MID);
            SPEED_LO:  pow = POW_W'(DIV_POW_SLOWEST);
            default:   pow = POW_W'(DIV_POW_FASTEST);
        endcase
        // HALT has no period to finish, so leaving it is immediate.
        boundary  = (cur == SPEED_HALT) || eop;
        do_switch = boundary && (target != cur);
        run       = (cur != SPEED_HALT) && !(do_switch && (target == SPEED_HALT));
    end

`ifdef MFP_CLOCK_SINGLE_STEP_EN
    // A step while the previous step pulse is still on clk_en is dropped.
    assign step_fire = step && (cur == SPEED_HALT) && !do_switch && !clk_en;
`else
    assign step_fire = 1'b0;
`endif

    // Software handshake: sys_req is a one-cycle strobe that latches sys_speed as
    // the override; sys_ack answers with exactly one pulse once that speed is in
    // effect. A newer sys_req restarts the wait; sys_rel alone cancels it.
    always_ff @(posedge clki) begin
        if (rst) begin
            cur       <= SPEED_FAST;
            sys_latch <= SPEED_FAST;
            override  <= 1'b0;
            ack_wait  <= 1'b0;
            sys_ack   <= 1'b0;
            pending   <= 1'b0;
        end else begin
            if (do_switch) begin
                cur <= target;
            end
            pending <= (target != cur) && !do_switch;

            if (sys_req) begin
                override  <= 1'b1;
                sys_latch <= req_speed;
                sys_ack   <= (cur == req_speed);
                ack_wait  <= (cur != req_speed);
            end else if (sys_rel) begin
                override <= 1'b0;
                sys_ack  <= 1'b0;
                ack_wait <= 1'b0;
            end else if (ack_wait && (cur == sys_latch)) begin
                sys_ack  <= 1'b1;
                ack_wait <= 1'b0;
            end else begin
                sys_ack <= 1'b0;
            end
        end
    end

    mfp_clock_tick_gen #(
        .CNT_W (DIV_POW_SLOWEST),
        .POW_W (POW_W)
    ) u_tick_gen (
        .clki      (clki),
        .rst       (rst),
        .pow       (pow),
        .run       (run),
        .clear     (do_switch),
        .step_fire (step_fire),
        .eop       (eop),
        .clk_en    (clk_en),
        .clko      (clko)
    );

endmodule

// File: tb/tb_mfp_clock_speed_controller.sv
// Directed bench for mfp_clock_speed_controller with periods 2 / 8 / 32 clki cycles.
module tb_mfp_clock_speed_controller;

    logic       clki;
    logic       rst;
    logic       sw_sel_lo;
    logic       sw_sel_mid;
    logic       ldr_active;
    logic       sys_req;
    logic [1:0] sys_speed;
    logic       sys_rel;
    logic       sys_ack;
    logic       step;
    logic       clk_en;
    logic       clko;
    logic [1:0] cur_speed;
    logic       pending;

    int n_checks = 0;
    int n_errors = 0;
    int n;
    int pulses;

    mfp_clock_speed_controller #(
        .DIV_POW_FASTEST (1),
        .DIV_POW_MID     (3),
        .DIV_POW_SLOWEST (5)
    ) dut (
        .clki       (clki),
        .rst        (rst),
        .sw_sel_lo  (sw_sel_lo),
        .sw_sel_mid (sw_sel_mid),
        .ldr_active (ldr_active),
        .sys_req    (sys_req),
        .sys_speed  (sys_speed),
        .sys_rel    (sys_rel),
        .sys_ack    (sys_ack),
`ifdef MFP_CLOCK_SINGLE_STEP_EN
        .step       (step),
`endif
        .clk_en     (clk_en),
        .clko       (clko),
        .cur_speed  (cur_speed),
        .pending    (pending)
    );

    // clock / reset
    initial begin
        clki = 1'b0;
        forever #5 clki = ~clki;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step_cycle();
        @(posedge clki);
        #1;
    endtask

    task automatic wait_cur(input logic [1:0] code, input int max_cycles, output int cnt);
        cnt = 0;
        do begin
            step_cycle();
            cnt++;
        end while (cur_speed != code && cnt < max_cycles);
        if (cur_speed != code) check("wait_cur_timeout", 32'(cur_speed), 32'(code));
    endtask

    task automatic wait_en(input int max_cycles, output int cnt);
        cnt = 0;
        do begin
            step_cycle();
            cnt++;
        end while (!clk_en && cnt < max_cycles);
        if (!clk_en) check("wait_en_timeout", 32'(clk_en), 32'd1);
    endtask

    task automatic pulse_req(input logic [1:0] spd);
        sys_req   = 1'b1;
        sys_speed = spd;
        step_cycle();
        sys_req   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sw_sel_lo = 1'b0; sw_sel_mid = 1'b0; ldr_active = 1'b0;
        sys_req = 1'b0; sys_speed = 2'd0; sys_rel = 1'b0; step = 1'b0;
        step_cycle();
        step_cycle();
        check("rst_clk_en", 32'(clk_en), 32'd0);
        check("rst_clko", 32'(clko), 32'd0);
        check("rst_cur", 32'(cur_speed), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_ack", 32'(sys_ack), 32'd0);
        rst = 1'b0;

        // FAST: period 2, pulse on every second edge
        for (int i = 1; i <= 4; i++) begin
            step_cycle();
            check("fast_clk_en", 32'(clk_en), (i % 2 == 0) ? 32'd1 : 32'd0);
            check("fast_clko", 32'(clko), (i % 2 == 0) ? 32'd1 : 32'd0);
        end

        // switch request LO
        sw_sel_lo = 1'b1;
        step_cycle();
        check("lo_pending", 32'(pending), 32'd1);
        check("lo_pending_cur", 32'(cur_speed), 32'd0);
        step_cycle();
        check("lo_switch_cur", 32'(cur_speed), 32'd2);
        check("lo_switch_pending", 32'(pending), 32'd0);
        wait_en(40, n);
        check("lo_first_pulse", 32'(n), 32'd32);
        check("lo_clko_high", 32'(clko), 32'd1);

        // software MID requested at cnt=5 of a LO period
        for (int i = 0; i < 5; i++) step_cycle();
        pulse_req(2'd1);
        step_cycle();
        check("mid_pending", 32'(pending), 32'd1);
        check("mid_wait_cur", 32'(cur_speed), 32'd2);
        wait_cur(2'd1, 40, n);
        check("mid_switch_delay", 32'(n), 32'd25);
        check("mid_switch_en", 32'(clk_en), 32'd1);
        check("mid_ack_early", 32'(sys_ack), 32'd0);
        step_cycle();
        check("mid_ack", 32'(sys_ack), 32'd1);
        step_cycle();
        check("mid_ack_single", 32'(sys_ack), 32'd0);
        wait_en(20, n);
        check("mid_first_pulse", 32'(n), 32'd6);
        wait_en(20, n);
        check("mid_period", 32'(n), 32'd8);

        // loader forces FAST, then MID override returns, then release to switches
        ldr_active = 1'b1;
        wait_cur(2'd0, 20, n);
        check("ldr_to_fast", 32'(n), 32'd8);
        ldr_active = 1'b0;
        wait_cur(2'd1, 20, n);
        check("ldr_back_mid", 32'(n), 32'd2);
        sys_rel = 1'b1;
        step_cycle();
        sys_rel = 1'b0;
        check("rel_no_reack", 32'(sys_ack), 32'd0);
        step_cycle();
        check("rel_pending", 32'(pending), 32'd1);
        wait_cur(2'd2, 20, n);
        check("rel_to_lo", 32'(n), 32'd6);

        // HALT through software
        pulse_req(2'd3);
        wait_cur(2'd3, 40, n);
        check("halt_delay", 32'(n), 32'd31);
        check("halt_en", 32'(clk_en), 32'd0);
        check("halt_clko", 32'(clko), 32'd0);
        step_cycle();
        check("halt_ack", 32'(sys_ack), 32'd1);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step_cycle();
            if (clk_en || clko) pulses++;
        end
        check("halt_stall", 32'(pulses), 32'd0);
        pulse_req(2'd0);
        check("unhalt_latch_cur", 32'(cur_speed), 32'd3);
        step_cycle();
        check("unhalt_cur", 32'(cur_speed), 32'd0);
        step_cycle();
        check("unhalt_ack", 32'(sys_ack), 32'd1);
        check("unhalt_en0", 32'(clk_en), 32'd0);
        step_cycle();
        check("unhalt_en1", 32'(clk_en), 32'd1);

        // req and rel together: req wins; speed already equal acks next cycle
        sys_rel = 1'b1;
        pulse_req(2'd0);
        sys_rel = 1'b0;
        check("same_ack", 32'(sys_ack), 32'd1);
        step_cycle();
        check("req_wins_pending", 32'(pending), 32'd0);
        check("same_ack_single", 32'(sys_ack), 32'd0);

        // release to LO, then drop switch and reset while pending
        sys_rel = 1'b1;
        step_cycle();
        sys_rel = 1'b0;
        wait_cur(2'd2, 8, n);
        sw_sel_lo = 1'b0;
        step_cycle();
        check("pre_rst_pending", 32'(pending), 32'd1);
        rst = 1'b1;
        step_cycle();
        check("mid_rst_cur", 32'(cur_speed), 32'd0);
        check("mid_rst_pending", 32'(pending), 32'd0);
        check("mid_rst_en", 32'(clk_en), 32'd0);
        check("mid_rst_clko", 32'(clko), 32'd0);
        rst = 1'b0;

`ifdef MFP_CLOCK_SINGLE_STEP_EN
        pulse_req(2'd3);
        wait_cur(2'd3, 8, n);
        check("step_halt_delay", 32'(n), 32'd1);
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            step_cycle();
            step = 1'b0;
            check("step_en", 32'(clk_en), 32'd1);
            check("step_clko", 32'(clko), 32'd1);
            if (clk_en) pulses++;
            for (int j = 0; j < 3; j++) begin
                step_cycle();
                if (clk_en) pulses++;
            end
        end
        check("step_count", 32'(pulses), 32'd3);
        step = 1'b1;
        step_cycle();
        check("step_held_first", 32'(clk_en), 32'd1);
        step_cycle();
        step = 1'b0;
        check("step_held_dropped", 32'(clk_en), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
